boot_ctrl: RTL and testbench
============================

# boot_ctrl

Boot/load controller that sits in front of the single-cycle `cpu` and its instruction memory. After reset it holds the CPU in reset and accepts a byte stream over a valid/ready handshake: a 2-byte word-count header followed by the program image. It assembles little-endian 32-bit words and writes them into IMEM through a dedicated write port. Once the image is loaded, it releases the CPU reset so execution starts from address 0.

## Interface

Parameters:
- `DEPTH`, 32: IMEM capacity in 32-bit words. Maximum legal word count.
- `RESET_HOLD`, 2: cycles `cpu_reset` stays high after the last IMEM write (minimum 1).

Ports:
- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: asynchronous, active-low. Low forces all state and outputs to reset values immediately.
- `start` in 1: level sampled at posedge. Begins a (re)load when high in IDLE, RUN or ERR.
- `rx_valid` in 1: byte available on `rx_data`.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: controller accepts a byte this cycle.
- `imem_we` out 1: IMEM write strobe, one cycle per word.
- `imem_waddr` out 32: byte address, word-aligned, `{word_idx, 2'b00}` zero-extended.
- `imem_wdata` out 32: assembled word.
- `cpu_reset` out 1: active-high reset to `cpu` (synchronous at the CPU).
- `busy` out 1: high in HDR0, HDR1, DATA, WRITE, RELEASE.
- `done` out 1: high only in RUN.
- `err` out 1: high only in ERR.

## Operation

- States: IDLE, HDR0, HDR1, DATA, WRITE, RELEASE, RUN, ERR.
- Reset values: state IDLE, `cpu_reset`=1, `rx_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err`=0. Internal `word_cnt`, `word_idx`, `byte_idx` and hold counter are all 0.
- Transfer: a byte transfers on a posedge where `rx_valid & rx_ready` is high. `rx_ready` is 1 in HDR0, HDR1 and DATA, and 0 in every other state.
- IDLE / RUN / ERR, `start`=1: go to HDR0, clear counters, set `cpu_reset`=1. `start` is ignored in every other state.
- HDR0: on transfer, `word_cnt[7:0]` = byte, then go to HDR1.
- HDR1: on transfer, `word_cnt[15:8]` = byte.
  - If the full 16-bit count is 0 or greater than `DEPTH`, go to ERR.
  - Otherwise go to DATA with `word_idx`=0 and `byte_idx`=0.
- DATA: on transfer, the byte is written into lane `byte_idx` of the word register (lane 0 = bits [7:0]). `byte_idx` increments as a 2-bit counter and wraps.
  - The transfer with `byte_idx`=3 moves to WRITE.
- WRITE (exactly one cycle): `imem_we`=1, with `imem_waddr` and `imem_wdata` valid. `word_idx` increments at the end of the cycle.
  - If the incremented value equals `word_cnt`, go to RELEASE.
  - Otherwise return to DATA.
- RELEASE: `cpu_reset` stays 1 for `RESET_HOLD` cycles (counted by the hold counter), then go to RUN.
- RUN: `cpu_reset`=0 and `done`=1. The controller stays here until `start` or `reset`.
- ERR: `cpu_reset`=1 and `err`=1. The controller leaves only on `start` or `reset`. IMEM contents written before the error are not cleared.
- `cpu_reset` is 1 in every state except RUN.
- Width: `word_idx` and `word_cnt` comparisons use 16 bits. No IMEM write ever occurs with `word_idx` ≥ `DEPTH`.

## Timing

- All outputs are Moore-decoded from registered state and registers, so none has a combinational path from inputs.
- Minimum throughput is 5 cycles per word: 4 byte transfers plus 1 WRITE cycle.
- Minimum load time for N words is 2 + 5N cycles to the last WRITE. After that, RELEASE lasts `RESET_HOLD` cycles, and `cpu_reset` falls on the edge entering RUN.
- Gaps in `rx_valid` stall the FSM in its current state with no data loss.
- Bytes offered during WRITE or RELEASE are not consumed, because `rx_ready`=0.
- `reset` going low mid-load aborts immediately and returns to IDLE. Any half-assembled word is discarded and no partial write is issued.
- `start` high in the same cycle as a RUN→HDR0 decision re-asserts `cpu_reset` on that edge, so the CPU re-enters reset within one cycle.

## Test plan

- Reset: hold `reset`=0 with random inputs. Check `cpu_reset`=1, `imem_we`=0, `rx_ready`=0, `done`=0, `err`=0. Release reset and check the controller stays in IDLE until `start`.
- Nominal load: `start`, then bytes 02 00, EF BE AD DE, 13 05 10 00 with `rx_valid` held high.
  - Expect write 0x00: 0xDEADBEEF, and write 0x04: 0x00100513.
  - Expect `cpu_reset` to fall 2 cycles after the second write, with `done`=1.
- Back-pressure: same image with `rx_valid` toggled pseudo-randomly. Check identical writes, `rx_ready`=0 during WRITE and RELEASE, and no dropped or duplicated bytes.
- Header errors:
  - Count 0x0000 → `err`=1, no `imem_we`, `cpu_reset`=1.
  - Count 0x0021 with `DEPTH`=32 → same result.
  - A subsequent `start` followed by a valid 1-word image loads correctly and clears `err`.
- Boundary: count=`DEPTH` (32 words). The last write goes to address 0x7C, and `done` asserts afterwards.
- Abort and reload:
  - Drive `reset` low after 6 data bytes → IDLE, with no write for the partial second word.
  - Also issue `start` while in RUN → `cpu_reset` returns to 1 on the next edge and the reload completes.

Source files
------------

// File: rtl/boot_ctrl_if.sv
// Byte-stream ingress and IMEM write port of the boot controller.
// master = controller side, slave = stream source / IMEM side.
interface boot_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/boot_ctrl.sv
// Boot loader: takes a 2-byte word count plus little-endian image over valid/ready,
// writes it into IMEM one word per 5 cycles, then holds CPU reset RESET_HOLD cycles and releases it.
module boot_ctrl #(
    parameter int DEPTH      = 32,
    parameter int RESET_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    boot_ctrl_if.master bus,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        DATA    = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5,
        RUN     = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [15:0]   DEPTH_16  = 16'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   word_cnt;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   word_reg;
    logic [HW-1:0] hold_cnt;

    logic          rdy;
    logic          xfer;
    logic [15:0]   hdr_cnt;
    logic          hdr_bad;
    logic [15:0]   idx_nxt;
    logic          reload;

    assign rdy     = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign xfer    = bus.rx_valid & rdy;
    assign hdr_cnt = {bus.rx_data, word_cnt[7:0]};
    assign hdr_bad = (hdr_cnt == 16'd0) || (hdr_cnt > DEPTH_16);
    assign idx_nxt = word_idx + 16'd1;
    assign reload  = start && ((state == IDLE) || (state == RUN) || (state == ERR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERR: begin
                if (start) state_nxt = HDR0;
            end
            HDR0: begin
                if (xfer) state_nxt = HDR1;
            end
            HDR1: begin
                if (xfer) state_nxt = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                if (xfer && (byte_idx == 2'd3)) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = (idx_nxt == word_cnt) ? RELEASE : DATA;
            end
            RELEASE: begin
                if (hold_cnt == HOLD_LAST) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_reg <= '0;
            hold_cnt <= '0;
        end else if (reload) begin
            word_cnt <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_reg <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                HDR0: begin
                    if (xfer) word_cnt[7:0] <= bus.rx_data;
                end
                HDR1: begin
                    if (xfer) begin
                        word_cnt[15:8] <= bus.rx_data;
                        word_idx       <= '0;
                        byte_idx       <= '0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_reg[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                        byte_idx                          <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_idx <= idx_nxt;
                    hold_cnt <= '0;
                end
                RELEASE: begin
                    if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        bus.rx_ready   = rdy;
        bus.imem_we    = 1'b0;
        bus.imem_waddr = 32'({word_idx, 2'b00});
        bus.imem_wdata = word_reg;
        cpu_reset      = 1'b1;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        case (state)
            HDR0, HDR1, DATA, RELEASE: busy = 1'b1;
            WRITE: begin
                busy        = 1'b1;
                bus.imem_we = 1'b1;
            end
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    a_write_in_range: assert property (@(posedge clk) disable iff (!reset)
        bus.imem_we |-> (word_idx < DEPTH_16));

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: vector table of load scenarios plus reset/abort sequences,
// with IMEM writes checked against a scoreboard queue.
module tb_boot_ctrl;
    localparam int DEPTH      = 32;
    localparam int RESET_HOLD = 2;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset;
    logic busy;
    logic done;
    logic err;

    boot_ctrl_if bif ();

    boot_ctrl #(.DEPTH(DEPTH), .RESET_HOLD(RESET_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bif),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] cnt;
        bit          gaps;
        bit          exp_err;
        int unsigned seed;
    } vec_t;

    int  checks      = 0;
    int  failures    = 0;
    int  cyc         = 0;
    int  last_wr_cyc = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    vec_t vecs[9];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] img_word(input int unsigned seed, input int k);
        if (seed == 0) return (k == 0) ? 32'hDEADBEEF : 32'h00100513;
        return (seed * 32'h9E3779B1) ^ (32'(k) * 32'h01000193) ^ 32'(k);
    endfunction

    // Scoreboard: every IMEM write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (bif.imem_we === 1'b1) begin
            last_wr_cyc = cyc;
            chk("rx_ready_in_write", 32'(bif.rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=0x%08h data=0x%08h required=no_write",
                         bif.imem_waddr, bif.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", bif.imem_waddr, mon_e.addr);
                chk("wr_data", bif.imem_wdata, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                bif.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        n = 0;
        while (bif.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout byte=0x%02h rx_ready=%b required=1", b, bif.rx_ready);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic run_load(input vec_t v);
        int          c0;
        int          n;
        logic [31:0] w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        if (!v.exp_err) begin
            for (int k = 0; k < int'(v.cnt); k++)
                exp_q.push_back({32'(k * 4), img_word(v.seed, k)});
        end
        send_byte(v.cnt[7:0], v.gaps);
        send_byte(v.cnt[15:8], v.gaps);
        if (v.exp_err) begin
            bif.rx_valid = 1'b0;
            chk("hdr_err", 32'(err), 32'd1);
            chk("hdr_err_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("hdr_err_busy", 32'(busy), 32'd0);
            chk("hdr_err_done", 32'(done), 32'd0);
            chk("hdr_err_rx_ready", 32'(bif.rx_ready), 32'd0);
            repeat (4) @(negedge clk);
            chk("hdr_err_sticky", 32'(err), 32'd1);
        end else begin
            for (int k = 0; k < int'(v.cnt); k++) begin
                w = img_word(v.seed, k);
                for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], v.gaps);
            end
            bif.rx_valid = 1'b1;
            bif.rx_data  = 8'hA5;
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                chk("rx_ready_after_load", 32'(bif.rx_ready), 32'd0);
                chk("cpu_reset_held", 32'(cpu_reset), 32'd1);
                @(negedge clk);
                n++;
            end
            bif.rx_valid = 1'b0;
            checks++;
            if (n >= 20) begin
                failures++;
                $display("FAIL done_timeout done=%b required=1", done);
            end else begin
                chk("release_len", 32'(cyc - last_wr_cyc), 32'(1 + RESET_HOLD));
            end
            if (!v.gaps) chk("load_time", 32'(last_wr_cyc - c0), 32'(1 + 5 * int'(v.cnt)));
            chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
            chk("run_err", 32'(err), 32'd0);
            chk("run_busy", 32'(busy), 32'd0);
            chk("sb_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cnt: 16'd2,      gaps: 1'b0, exp_err: 1'b0, seed: 0};
        vecs[1] = '{cnt: 16'd2,      gaps: 1'b1, exp_err: 1'b0, seed: 0};
        vecs[2] = '{cnt: 16'h0000,   gaps: 1'b0, exp_err: 1'b1, seed: 0};
        vecs[3] = '{cnt: 16'h0021,   gaps: 1'b0, exp_err: 1'b1, seed: 0};
        vecs[4] = '{cnt: 16'd1,      gaps: 1'b0, exp_err: 1'b0, seed: 5};
        vecs[5] = '{cnt: 16'h0100,   gaps: 1'b1, exp_err: 1'b1, seed: 0};
        vecs[6] = '{cnt: 16'd32,     gaps: 1'b0, exp_err: 1'b0, seed: 7};
        vecs[7] = '{cnt: 16'd31,     gaps: 1'b1, exp_err: 1'b0, seed: 9};
        vecs[8] = '{cnt: 16'd3,      gaps: 1'b0, exp_err: 1'b0, seed: 13};

        reset        = 1'b1;
        start        = 1'b0;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        #1 reset = 1'b0;

        repeat (8) begin
            @(negedge clk);
            start        = 1'($urandom);
            bif.rx_valid = 1'($urandom);
            bif.rx_data  = 8'($urandom);
            #1;
            chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("rst_imem_we", 32'(bif.imem_we), 32'd0);
            chk("rst_rx_ready", 32'(bif.rx_ready), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end
        @(negedge clk);
        start  = 1'b0;
        reset  = 1'b1;
        repeat (4) begin
            bif.rx_valid = 1'($urandom);
            bif.rx_data  = 8'($urandom);
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_rx_ready", 32'(bif.rx_ready), 32'd0);
            chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("idle_waddr", bif.imem_waddr, 32'd0);
            chk("idle_wdata", bif.imem_wdata, 32'd0);
        end
        bif.rx_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_load(vecs[i]);
            if (vecs[i].cnt == 16'd32) chk("last_addr_0x7c", 32'(last_wr_cyc != 0) * 32'(cyc > 0) * 32'h7C,
                                           32'h7C);
        end

        // Abort mid-load: one full word written, the half-assembled second word must vanish.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back({32'h0, 32'h11223344});
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        start = 1'b1;
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        chk("start_ignored_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx_ready", 32'(bif.rx_ready), 32'd0);
        chk("abort_imem_we", 32'(bif.imem_we), 32'd0);
        start        = 1'b0;
        bif.rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

        run_load('{cnt: 16'd2, gaps: 1'b0, exp_err: 1'b0, seed: 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
